// File: rtl/ifetch_line_buffer_pkg.sv
// Shared state type and default geometry for the instruction-fetch line buffer.
package params;

    localparam int unsigned LINE_WORDS_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RESP     = 2'd1,
        FILL     = 2'd2,
        PREFETCH = 2'd3
    } ilb_state_t;

endpackage

// File: rtl/ifetch_line_buffer_if.sv
// Fetch-side (ufp) and memory-side (dfp) signals of the instruction-fetch line buffer.
// slave is the buffer's view; master is the fetch unit plus memory model.
interface ifetch_line_buffer_if
    import params::*;
#(
    parameter int unsigned LINE_WORDS = LINE_WORDS_DEFAULT
);
    logic [31:0]              ufp_addr;
    logic                     ufp_read;
    logic                     ufp_resp;
    logic [31:0]              ufp_rdata;
    logic                     inval;
    logic [31:0]              dfp_addr;
    logic                     dfp_read;
    logic [32*LINE_WORDS-1:0] dfp_rdata;
    logic                     dfp_resp;

    modport slave (
        input  ufp_addr, ufp_read, inval, dfp_rdata, dfp_resp,
        output ufp_resp, ufp_rdata, dfp_addr, dfp_read
    );

    modport master (
        output ufp_addr, ufp_read, inval, dfp_rdata, dfp_resp,
        input  ufp_resp, ufp_rdata, dfp_addr, dfp_read
    );
endinterface

// File: rtl/ifetch_line_buffer_line.sv
// One buffered line: data words, tag, valid bit and the lookup word mux.
module ilb_line
    import params::*;
#(
    parameter  int unsigned LINE_WORDS = LINE_WORDS_DEFAULT,
    localparam int unsigned IDX_W      = $clog2(LINE_WORDS),
    localparam int unsigned TAG_W      = 32 - $clog2(4 * LINE_WORDS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     we,
    input  logic                     wvalid,
    input  logic [TAG_W-1:0]         wtag,
    input  logic [32*LINE_WORDS-1:0] wdata,
    input  logic [TAG_W-1:0]         rtag,
    input  logic [IDX_W-1:0]         ridx,
    output logic                     hit_c,
    output logic [31:0]              word_c
);
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      words [LINE_WORDS];

    // A write carries its own validity so an invalidate racing a fill wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (we) begin
            valid <= wvalid;
        end else if (clr) begin
            valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tag <= wtag;
            for (int i = 0; i < LINE_WORDS; i++) begin
                words[i] <= wdata[32*i +: 32];
            end
        end
    end

    assign hit_c  = valid && (tag == rtag);
    assign word_c = words[ridx];
endmodule

// File: rtl/ifetch_line_buffer.sv
// Instruction-fetch line buffer: one-cycle hits, single outstanding line fill.
// Define ILB_PREFETCH_EN to add a next-line prefetch buffer.
module ifetch_line_buffer
    import params::*;
#(
    parameter int unsigned LINE_WORDS = LINE_WORDS_DEFAULT
) (
    input logic                 clk,
    input logic                 rst_n,
    ifetch_line_buffer_if.slave bus
);
    localparam int unsigned OFF   = $clog2(4 * LINE_WORDS);
    localparam int unsigned IDX_W = OFF - 2;
    localparam int unsigned TAG_W = 32 - OFF;
`ifdef ILB_PREFETCH_EN
    localparam int unsigned NLINES = 2;
`else
    localparam int unsigned NLINES = 1;
`endif

    ilb_state_t       state, state_d;
    logic             resp_q, resp_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             dread_q, dread_d;
    logic [TAG_W-1:0] dtag_q, dtag_d;
    logic [IDX_W-1:0] req_idx, req_idx_d;
    logic             stale_q, stale_d;
    logic             main_we;
    logic             wvalid_c;

    logic [TAG_W-1:0] a_tag;
    logic [IDX_W-1:0] a_idx;
    logic             unused_addr_bits;
    logic [31:0]      fill_words [LINE_WORDS];

    logic             line_we   [NLINES];
    logic             line_clr  [NLINES];
    logic             line_hit  [NLINES];
    logic [31:0]      line_word [NLINES];
    logic             main_hit_c;
    logic [31:0]      main_word_c;

    assign a_tag            = bus.ufp_addr[31:OFF];
    assign a_idx            = bus.ufp_addr[OFF-1:2];
    assign unused_addr_bits = ^bus.ufp_addr[1:0];
    assign wvalid_c         = ~(stale_q | bus.inval);

`ifdef ILB_PREFETCH_EN
    logic        main_sel, main_sel_d;
    logic        pf_go, pf_go_d;
    logic        pf_we, promote;
    logic        pf_hit_c;
    logic [31:0] pf_word_c;

    assign main_hit_c  = line_hit[main_sel];
    assign main_word_c = line_word[main_sel];
    assign pf_hit_c    = line_hit[~main_sel];
    assign pf_word_c   = line_word[~main_sel];
`else
    assign main_hit_c  = line_hit[0];
    assign main_word_c = line_word[0];
`endif

    always_comb begin
        for (int i = 0; i < LINE_WORDS; i++) begin
            fill_words[i] = bus.dfp_rdata[32*i +: 32];
        end
    end

    // Route fills to the main or prefetch slot; promotion discards the old main.
    always_comb begin
        for (int i = 0; i < NLINES; i++) begin
            line_we[i]  = 1'b0;
            line_clr[i] = bus.inval;
        end
`ifdef ILB_PREFETCH_EN
        line_we[main_sel]  = main_we;
        line_we[~main_sel] = pf_we;
        line_clr[main_sel] = bus.inval | promote;
`else
        line_we[0] = main_we;
`endif
    end

    for (genvar g = 0; g < NLINES; g++) begin : g_line
        ilb_line #(.LINE_WORDS(LINE_WORDS)) u_line (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr    (line_clr[g]),
            .we     (line_we[g]),
            .wvalid (wvalid_c),
            .wtag   (dtag_q),
            .wdata  (bus.dfp_rdata),
            .rtag   (a_tag),
            .ridx   (a_idx),
            .hit_c  (line_hit[g]),
            .word_c (line_word[g])
        );
    end

    // Next state and next values of the registered outputs.
    always_comb begin
        state_d   = state;
        resp_d    = 1'b0;
        rdata_d   = '0;
        dread_d   = dread_q;
        dtag_d    = dtag_q;
        req_idx_d = req_idx;
        stale_d   = stale_q | (bus.inval & dread_q);
        main_we   = 1'b0;
`ifdef ILB_PREFETCH_EN
        main_sel_d = main_sel;
        pf_go_d    = 1'b0;
        pf_we      = 1'b0;
        promote    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (bus.ufp_read) begin
                    req_idx_d = a_idx;
                    if (main_hit_c && !bus.inval) begin
                        state_d = RESP;
                        resp_d  = 1'b1;
                        rdata_d = main_word_c;
                    end
`ifdef ILB_PREFETCH_EN
                    else if (pf_hit_c && !bus.inval) begin
                        state_d    = RESP;
                        resp_d     = 1'b1;
                        rdata_d    = pf_word_c;
                        promote    = 1'b1;
                        main_sel_d = ~main_sel;
                    end
`endif
                    else begin
                        state_d = FILL;
                        dread_d = 1'b1;
                        dtag_d  = a_tag;
                        stale_d = 1'b0;
                    end
                end
            end
            FILL: begin
                if (bus.dfp_resp) begin
                    main_we = 1'b1;
                    state_d = RESP;
                    resp_d  = 1'b1;
                    rdata_d = fill_words[req_idx];
                    dread_d = 1'b0;
`ifdef ILB_PREFETCH_EN
                    pf_go_d = 1'b1;
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
`ifdef ILB_PREFETCH_EN
                // A prefetch may complete while a main-line hit is being answered.
                if (dread_q) begin
                    if (bus.dfp_resp) begin
                        pf_we   = 1'b1;
                        dread_d = 1'b0;
                    end else begin
                        state_d = PREFETCH;
                    end
                end else if (pf_go) begin
                    state_d = PREFETCH;
                    dread_d = 1'b1;
                    dtag_d  = dtag_q + TAG_W'(1);
                    stale_d = 1'b0;
                end
`endif
            end
`ifdef ILB_PREFETCH_EN
            PREFETCH: begin
                if (bus.dfp_resp) begin
                    pf_we   = 1'b1;
                    dread_d = 1'b0;
                    state_d = IDLE;
                end else if (bus.ufp_read && main_hit_c && !bus.inval) begin
                    state_d = RESP;
                    resp_d  = 1'b1;
                    rdata_d = main_word_c;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            resp_q  <= 1'b0;
            rdata_q <= '0;
            dread_q <= 1'b0;
            dtag_q  <= '0;
            req_idx <= '0;
            stale_q <= 1'b0;
`ifdef ILB_PREFETCH_EN
            main_sel <= 1'b0;
            pf_go    <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
            dread_q <= dread_d;
            dtag_q  <= dtag_d;
            req_idx <= req_idx_d;
            stale_q <= stale_d;
`ifdef ILB_PREFETCH_EN
            main_sel <= main_sel_d;
            pf_go    <= pf_go_d;
`endif
        end
    end

    assign bus.ufp_resp  = resp_q;
    assign bus.ufp_rdata = rdata_q;
    assign bus.dfp_read  = dread_q;
    assign bus.dfp_addr  = {dtag_q, {OFF{1'b0}}};
endmodule

// File: tb/tb_ifetch_line_buffer.sv
// Self-checking bench for ifetch_line_buffer: directed scenarios plus randomized
// fetch/invalidate traffic checked against a one-line buffer model.
module tb_ifetch_line_buffer;
    localparam int unsigned LW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    ifetch_line_buffer_if #(.LINE_WORDS(LW)) bus ();

    ifetch_line_buffer #(.LINE_WORDS(LW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a & ~32'(4 * LW - 1);
    endfunction

    // Backing memory contents: fixed function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w == 32'h1eceb000) return 32'h0000_0013;
        return (w * 32'h9e37_79b1) ^ 32'h5bd1_e995;
    endfunction

    function automatic logic [32*LW-1:0] line_data(input logic [31:0] a);
        logic [32*LW-1:0] d;
        for (int i = 0; i < LW; i++) d[32*i +: 32] = mem_word(line_of(a) + 32'(4 * i));
        return d;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One fetch starting at a negedge with the buffer idle; returns at the
    // negedge after the response cycle. filled_valid = model validity afterwards.
    task automatic do_req(input logic [31:0] addr, input bit exp_hit, input bit inv_acc,
                          input int dly, input int ik, output bit filled_valid);
        bus.ufp_addr = addr;
        bus.ufp_read = 1'b1;
        bus.inval    = inv_acc;
        @(negedge clk);
        bus.ufp_read = 1'b0;
        bus.inval    = 1'b0;
        bus.ufp_addr = $urandom;
        if (exp_hit) begin
            check("hit_resp", 32'(bus.ufp_resp), 32'd1);
            check("hit_rdata", bus.ufp_rdata, mem_word(addr));
            check("hit_no_dfp", 32'(bus.dfp_read), 32'd0);
            filled_valid = 1'b1;
        end else begin
            check("miss_dfp_read", 32'(bus.dfp_read), 32'd1);
            check("miss_dfp_addr", bus.dfp_addr, line_of(addr));
            check("miss_no_resp", 32'(bus.ufp_resp), 32'd0);
            for (int k = 0; k < dly; k++) begin
                bus.inval = (k == ik);
                @(negedge clk);
                bus.inval = 1'b0;
                check("fill_hold_read", 32'(bus.dfp_read), 32'd1);
                check("fill_hold_addr", bus.dfp_addr, line_of(addr));
                check("fill_no_resp", 32'(bus.ufp_resp), 32'd0);
            end
            bus.dfp_resp  = 1'b1;
            bus.dfp_rdata = line_data(addr);
            bus.inval     = (ik == dly);
            @(negedge clk);
            bus.dfp_resp  = 1'b0;
            bus.inval     = 1'b0;
            bus.dfp_rdata = line_data($urandom);
            check("fill_resp", 32'(bus.ufp_resp), 32'd1);
            check("fill_rdata", bus.ufp_rdata, mem_word(addr));
            check("fill_read_drop", 32'(bus.dfp_read), 32'd0);
            filled_valid = (ik > dly);
        end
        @(negedge clk);
        check("resp_single", 32'(bus.ufp_resp), 32'd0);
        check("rdata_idle", bus.ufp_rdata, 32'd0);
    endtask

    initial begin
        bit v;
`ifndef ILB_PREFETCH_EN
        bit          rv;
        bit          ia;
        bit          hit;
        logic [31:0] rline;
        logic [31:0] a;
        int          d;
        int          ik;
        logic [31:0] pool [4];
        pool = '{32'h1eceb000, 32'h1eceb020, 32'h0000_0040, 32'h7fff_ffe0};
`endif
        bus.ufp_addr  = '0;
        bus.ufp_read  = 1'b0;
        bus.inval     = 1'b0;
        bus.dfp_rdata = '0;
        bus.dfp_resp  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_resp", 32'(bus.ufp_resp), 32'd0);
        check("rst_rdata", bus.ufp_rdata, 32'd0);
        check("rst_dfp_read", 32'(bus.dfp_read), 32'd0);
        check("rst_dfp_addr", bus.dfp_addr, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // First fetch misses and fills; word 0 is a NOP.
        do_req(32'h1eceb000, 1'b0, 1'b0, 2, 99, v);

`ifndef ILB_PREFETCH_EN
        do_req(32'h1eceb01c, 1'b1, 1'b0, 0, 99, v);
        bus.inval = 1'b1;
        @(negedge clk);
        bus.inval = 1'b0;
        do_req(32'h1eceb004, 1'b0, 1'b0, 1, 99, v);
        rv    = v;
        rline = 32'h1eceb000;

        for (int t = 0; t < 300; t++) begin
            a   = line_of(pool[$urandom_range(0, 3)]) | 32'($urandom_range(0, LW - 1) << 2)
                | 32'($urandom_range(0, 3));
            ia  = ($urandom_range(0, 7) == 0);
            d   = $urandom_range(0, 3);
            ik  = $urandom_range(0, 7);
            hit = rv && (line_of(a) == rline) && !ia;
            do_req(a, hit, ia, d, ik, v);
            rv    = v;
            rline = line_of(a);
            if ($urandom_range(0, 9) == 0) begin
                bus.inval = 1'b1;
                @(negedge clk);
                bus.inval = 1'b0;
                rv = 1'b0;
            end
        end

        // Reset in the middle of a fill abandons it and clears the buffer.
        do_req(32'h1eceb010, rv && (rline == 32'h1eceb000), 1'b0, 1, 99, v);
        bus.ufp_addr = 32'h0000_2000;
        bus.ufp_read = 1'b1;
        @(negedge clk);
        bus.ufp_read = 1'b0;
        check("pre_rst_fill", 32'(bus.dfp_read), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_fill_read", 32'(bus.dfp_read), 32'd0);
        check("rst_fill_addr", bus.dfp_addr, 32'd0);
        check("rst_fill_resp", 32'(bus.ufp_resp), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_resp", 32'(bus.ufp_resp), 32'd0);
        check("post_rst_read", 32'(bus.dfp_read), 32'd0);
        @(negedge clk);
        check("post_rst_resp2", 32'(bus.ufp_resp), 32'd0);
        do_req(32'h1eceb010, 1'b0, 1'b0, 0, 99, v);
`else
        // Next line is requested right after the fill's response.
        check("pf_read", 32'(bus.dfp_read), 32'd1);
        check("pf_addr", bus.dfp_addr, 32'h1eceb020);
        bus.ufp_addr = 32'h1eceb01c;
        bus.ufp_read = 1'b1;
        @(negedge clk);
        bus.ufp_read = 1'b0;
        check("pf_main_hit_resp", 32'(bus.ufp_resp), 32'd1);
        check("pf_main_hit_rdata", bus.ufp_rdata, mem_word(32'h1eceb01c));
        check("pf_main_hit_hold", 32'(bus.dfp_read), 32'd1);
        @(negedge clk);
        check("pf_back_resp", 32'(bus.ufp_resp), 32'd0);
        check("pf_back_read", 32'(bus.dfp_read), 32'd1);
        bus.dfp_resp  = 1'b1;
        bus.dfp_rdata = line_data(32'h1eceb020);
        @(negedge clk);
        bus.dfp_resp = 1'b0;
        check("pf_done_read", 32'(bus.dfp_read), 32'd0);
        do_req(32'h1eceb024, 1'b1, 1'b0, 0, 99, v);
        do_req(32'h1eceb000, 1'b0, 1'b0, 0, 99, v);
        bus.dfp_resp  = 1'b1;
        bus.dfp_rdata = line_data(32'h1eceb020);
        @(negedge clk);
        bus.dfp_resp = 1'b0;
        bus.inval    = 1'b1;
        @(negedge clk);
        bus.inval = 1'b0;
        do_req(32'hffffffe4, 1'b0, 1'b0, 0, 99, v);
        check("pf_wrap_read", 32'(bus.dfp_read), 32'd1);
        check("pf_wrap_addr", bus.dfp_addr, 32'h0000_0000);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
